// File: rtl/aes_uart_pkg.sv
// rtl/aes_uart_pkg.sv - shared types and constants for the AES UART front end
// Purpose: receiver FSM state encoding, block geometry and default baud divisor.
package aes_uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    localparam int BLOCK_BYTES          = 32;   // 16 plaintext + 16 key bytes
    localparam int HALF_BYTES           = 16;
    localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: synchronizer, baud counter, bit FSM
// Purpose: recovers one byte per UART frame, sampling mid-bit.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_rx             raw serial line, idle high
//   o_byte[7:0]      last received byte (valid while o_byte_valid is high)
//   o_byte_valid     one-cycle pulse in the cycle of a good stop-bit sample
//   o_frame_err      one-cycle pulse in the cycle of a bad stop-bit sample
//   o_state          current FSM state
module uart_rx_byte
    import aes_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output rx_state_t  o_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    // Counter starts at 0 the cycle after the edge, so terminal values are one less
    // than the required cycle offsets.
    localparam logic [CW-1:0] HALF_M1 = CW'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic            r_sync1, r_sync2;
    rx_state_t       r_state, w_state_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [2:0]      r_bit, w_bit_next;
    logic [7:0]      r_shift, w_shift_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        o_byte_valid = 1'b0;
        o_frame_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!r_sync2) w_state_next = S_START;
            end
            S_START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    // A high line at mid-start is a glitch: drop it silently.
                    w_state_next = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next   = '0;
                    w_shift_next = {r_sync2, r_shift[7:1]};   // LSB first
                    if (r_bit == 3'd7) w_state_next = S_STOP;
                    else               w_bit_next   = r_bit + 3'd1;
                end
            end
            S_STOP: begin
                if (r_cnt == FULL_M1) begin
                    // Return to IDLE from mid-stop so a back-to-back start edge is not missed.
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                    o_byte_valid = r_sync2;
                    o_frame_err  = !r_sync2;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign o_byte  = r_shift;
    assign o_state = r_state;

endmodule

// File: rtl/uart_rx_block.sv
// rtl/uart_rx_block.sv - UART front end assembling 128-bit plaintext and key for AES
// Purpose: collects 32 bytes (16 data then 16 key), presents them as stable words.
// Optional feature: define UART_RX_TIMEOUT_EN to discard a partial block after
// TIMEOUT_BITS idle bit-times.
// Ports:
//   CLK100MHZ, RST   clock, asynchronous active-high reset
//   i_Rx             serial input, idle high
//   o_data, o_key    assembled plaintext / key (change only on block load)
//   o_valid          one-cycle pulse on block load
//   o_newKey         with o_valid when the key differs or first block since reset
//   o_busy           partial block held or byte in flight
//   o_frame_err      one-cycle pulse on a bad stop bit
module uart_rx_block
    import aes_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic         CLK100MHZ,
    input  logic         RST,
    input  logic         i_Rx,
    output logic [127:0] o_data,
    output logic [127:0] o_key,
    output logic         o_valid,
    output logic         o_newKey,
    output logic         o_busy,
    output logic         o_frame_err
);

    if (CLKS_PER_BIT < 8 || TIMEOUT_BITS < 1) begin : g_param_check
        $error("uart_rx_block: CLKS_PER_BIT must be >= 8 and TIMEOUT_BITS >= 1");
    end

    logic [7:0]   w_byte;
    logic         w_byte_valid;
    logic         w_frame_err;
    rx_state_t    w_state;
    logic         w_active;
    logic         w_timeout;
    logic [127:0] w_key_next;

    logic [4:0]   r_bcnt;
    logic [127:0] r_data_sh;
    logic [127:0] r_key_sh;
    logic         r_seen;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_byte (
        .i_clk        (CLK100MHZ),
        .i_rst        (RST),
        .i_rx         (i_Rx),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err),
        .o_state      (w_state)
    );

    // Only a confirmed start bit counts as a byte in flight, so line glitches
    // never raise o_busy.
    assign w_active   = (w_state == S_DATA) || (w_state == S_STOP);
    assign o_busy     = (r_bcnt != 5'd0) || w_active;
    assign w_key_next = {r_key_sh[119:0], w_byte};

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW        = $clog2(TO_CYCLES);

    logic [TW-1:0] r_idle_cnt;
    logic          w_idle_run;

    assign w_idle_run = (w_state == S_IDLE) && (r_bcnt != 5'd0);
    assign w_timeout  = w_idle_run && (r_idle_cnt == TW'(TO_CYCLES - 1));

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST)                          r_idle_cnt <= '0;
        else if (!w_idle_run || w_timeout) r_idle_cnt <= '0;
        else                              r_idle_cnt <= r_idle_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            r_bcnt      <= '0;
            r_data_sh   <= '0;
            r_key_sh    <= '0;
            r_seen      <= 1'b0;
            o_data      <= '0;
            o_key       <= '0;
            o_valid     <= 1'b0;
            o_newKey    <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_newKey    <= 1'b0;
            o_frame_err <= w_frame_err;
            if (w_frame_err || w_timeout) begin
                // Drop the whole partial block so framing restarts at byte 0.
                r_bcnt    <= '0;
                r_data_sh <= '0;
                r_key_sh  <= '0;
            end else if (w_byte_valid) begin
                if (r_bcnt == 5'(BLOCK_BYTES - 1)) begin
                    o_data   <= r_data_sh;
                    o_key    <= w_key_next;
                    o_valid  <= 1'b1;
                    o_newKey <= !r_seen || (w_key_next != o_key);
                    r_seen   <= 1'b1;
                end else if (r_bcnt < 5'(HALF_BYTES)) begin
                    r_data_sh <= {r_data_sh[119:0], w_byte};
                end else begin
                    r_key_sh <= w_key_next;
                end
                r_bcnt <= r_bcnt + 5'd1;   // 31 wraps to 0
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_block.sv
// tb/tb_uart_rx_block.sv - directed self-checking bench for uart_rx_block
module tb_uart_rx_block;

    localparam int CPB = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx;
    logic [127:0] o_data, o_key;
    logic         o_valid, o_newKey, o_busy, o_frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    int           valid_cnt = 0, ferr_cnt = 0, busy_hits = 0;
    logic [127:0] cap_data, cap_key;
    logic         cap_newkey, cap_busy;

    localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1B = 128'h000102030405060708090a0b0c0d0e0e;
    localparam logic [127:0] D2 = 128'hdeadbeef0123456789abcdefcafef00d;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    uart_rx_block #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(40)) dut (
        .CLK100MHZ   (clk),
        .RST         (rst),
        .i_Rx        (rx),
        .o_data      (o_data),
        .o_key       (o_key),
        .o_valid     (o_valid),
        .o_newKey    (o_newKey),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_valid) begin
            valid_cnt  <= valid_cnt + 1;
            cap_data   <= o_data;
            cap_key    <= o_key;
            cap_newkey <= o_newKey;
            cap_busy   <= o_busy;
        end
        if (o_frame_err) ferr_cnt  <= ferr_cnt + 1;
        if (o_busy)      busy_hits <= busy_hits + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        if (bad_stop) begin
            // Short low stop: sampled low mid-bit, back high before a re-triggered start is confirmed.
            rx = 1'b0;
            repeat (12) @(negedge clk);
            rx = 1'b1;
            repeat (CPB + 4) @(negedge clk);
        end else begin
            rx = 1'b1;
            repeat (CPB + 4) @(negedge clk);
        end
    endtask

    task automatic send_block(input logic [127:0] d, input logic [127:0] k);
        for (int i = 0; i < 16; i++) send_byte(d[127-8*i -: 8], 1'b0);
        for (int i = 0; i < 16; i++) send_byte(k[127-8*i -: 8], 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_block(input string tag, input int v0, input logic [127:0] d,
                               input logic [127:0] k, input logic nk);
        check({tag, "_valid_cnt"}, 128'(valid_cnt - v0), 128'd1);
        check({tag, "_data"},      cap_data, d);
        check({tag, "_key"},       cap_key, k);
        check({tag, "_newkey"},    128'(cap_newkey), 128'(nk));
        check({tag, "_busy_at_valid"}, 128'(cap_busy), 128'd0);
    endtask

    initial begin
        int v0, f0, b0;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data",  o_data, 128'd0);
        check("rst_key",   o_key, 128'd0);
        check("rst_valid", 128'(o_valid), 128'd0);
        check("rst_newkey", 128'(o_newKey), 128'd0);
        check("rst_busy",  128'(o_busy), 128'd0);
        check("rst_ferr",  128'(o_frame_err), 128'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        v0 = valid_cnt;
        send_block(D1, K1);
        check_block("fips", v0, D1, K1, 1'b1);
        check("fips_busy_after", 128'(o_busy), 128'd0);

        v0 = valid_cnt;
        send_block(D1, K1);
        check_block("same_key", v0, D1, K1, 1'b0);

        v0 = valid_cnt;
        send_block(D1, K1B);
        check_block("key_last_byte", v0, D1, K1B, 1'b1);

        v0 = valid_cnt;
        f0 = ferr_cnt;
        for (int i = 0; i < 5; i++) send_byte(D2[127-8*i -: 8], 1'b0);
        send_byte(D2[127-40 -: 8], 1'b1);
        check("bad_stop_ferr", 128'(ferr_cnt - f0), 128'd1);
        check("bad_stop_no_valid", 128'(valid_cnt - v0), 128'd0);
        check("bad_stop_busy", 128'(o_busy), 128'd0);
        check("bad_stop_data_hold", o_data, D1);
        check("bad_stop_key_hold", o_key, K1B);
        v0 = valid_cnt;
        send_block(D2, K2);
        check_block("after_err", v0, D2, K2, 1'b1);

        v0 = valid_cnt;
        f0 = ferr_cnt;
        b0 = busy_hits;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_busy", 128'(busy_hits - b0), 128'd0);
        check("glitch_ferr", 128'(ferr_cnt - f0), 128'd0);
        check("glitch_valid", 128'(valid_cnt - v0), 128'd0);

        for (int i = 0; i < 16; i++) send_byte(D1[127-8*i -: 8], 1'b0);
        for (int i = 0; i < 5; i++) send_byte(K1[127-8*i -: 8], 1'b0);
        check("pre_rst_busy", 128'(o_busy), 128'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_data", o_data, 128'd0);
        check("mid_rst_key",  o_key, 128'd0);
        check("mid_rst_busy", 128'(o_busy), 128'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        v0 = valid_cnt;
        send_block(D1, K1);
        check_block("after_rst", v0, D1, K1, 1'b1);

`ifdef UART_RX_TIMEOUT_EN
        for (int i = 0; i < 10; i++) send_byte(D2[127-8*i -: 8], 1'b0);
        check("to_busy_partial", 128'(o_busy), 128'd1);
        repeat (40 * CPB + 8) @(negedge clk);
        check("to_busy_cleared", 128'(o_busy), 128'd0);
        v0 = valid_cnt;
        send_block(D2, K2);
        check_block("after_timeout", v0, D2, K2, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
